// File: rtl/core_sequencer.sv
// -----------------------------------------------------------------------------
// core_sequencer
// Multi-cycle control sequencer for an RV32I core. Each instruction walks
// FETCH -> DECODE -> EXECUTE -> [MEM] -> WRITEBACK. The instruction word is
// captured into the IR in DECODE. Every control and status output is taken
// directly from a flop.
//
// Optional feature: define CORE_SEQUENCER_TRAP_EN to enable the TRAP state.
// With it defined, an unrecognised opcode halts the sequencer until reset.
// Without it, an unrecognised opcode executes as a NOP and halted_o is tied 0.
//
// Ports
//   clk_i           : clock, all state changes on the rising edge
//   rst_i           : synchronous active-high reset
//   instruction_i   : fetched instruction word, sampled in DECODE
//   cmp_i           : datapath branch condition, sampled at the end of EXECUTE
//   mem_ready_i     : load/store completion, while mem_req_o is high
//   fetch_en_o      : fetch strobe (FETCH only)
//   pc_inc_o        : PC += 4 (WRITEBACK)
//   pc_load_o       : PC <= target (WRITEBACK)
//   regfile_write_o : register-file write enable (WRITEBACK)
//   waddr_o, raddra_o, raddrb_o : register-file addresses from the IR
//   alu_op_o, alu_alt_op_o, alu_src_imm_o : ALU control and operand-2 select
//   imm_o           : sign-extended immediate
//   mem_req_o, mem_write_o : load/store request and direction (MEM)
//   wb_sel_o        : writeback source 00 ALU, 01 mem, 10 PC+4, 11 imm
//   state_o         : current state encoding
//   retired_o       : retired-instruction counter, wraps
//   halted_o        : high while trapped
// -----------------------------------------------------------------------------
module core_sequencer #(
  parameter int ICOUNT_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [31:0]         instruction_i,
  input  logic                cmp_i,
  input  logic                mem_ready_i,
  output logic                fetch_en_o,
  output logic                pc_inc_o,
  output logic                pc_load_o,
  output logic                regfile_write_o,
  output logic [4:0]          waddr_o,
  output logic [4:0]          raddra_o,
  output logic [4:0]          raddrb_o,
  output logic [2:0]          alu_op_o,
  output logic                alu_alt_op_o,
  output logic                alu_src_imm_o,
  output logic [31:0]         imm_o,
  output logic                mem_req_o,
  output logic                mem_write_o,
  output logic [1:0]          wb_sel_o,
  output logic [2:0]          state_o,
  output logic [ICOUNT_W-1:0] retired_o,
  output logic                halted_o
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

`ifdef CORE_SEQUENCER_TRAP_EN
  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4
  } state_t;
`endif

  // One bundle holding every control output so they share a single register.
  typedef struct packed {
    logic        fetch_en;
    logic        pc_inc;
    logic        pc_load;
    logic        rf_we;
    logic [4:0]  waddr;
    logic [4:0]  raddra;
    logic [4:0]  raddrb;
    logic [2:0]  alu_op;
    logic        alu_alt;
    logic        alu_src_imm;
    logic [31:0] imm;
    logic        mem_req;
    logic        mem_write;
    logic [1:0]  wb_sel;
`ifdef CORE_SEQUENCER_TRAP_EN
    logic        halted;
`endif
  } ctrl_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [31:0]         r_ir;
  logic [31:0]         w_ir_nxt;
  logic                r_taken;
  logic                w_taken_nxt;
  ctrl_t               r_ctrl;
  ctrl_t               w_ctrl_nxt;
  logic [ICOUNT_W-1:0] r_retired;

  // ---------------------------------------------------------------------------
  // Opcode classification and immediate formation
  // ---------------------------------------------------------------------------
  function automatic logic is_known(input logic [6:0] opc);
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
      OPC_STORE, OPC_OPIMM, OPC_OP, OPC_MISC, OPC_SYSTEM: is_known = 1'b1;
      default:                                            is_known = 1'b0;
    endcase
  endfunction

  function automatic logic is_mem(input logic [6:0] opc);
    is_mem = (opc == OPC_LOAD) || (opc == OPC_STORE);
  endfunction

  function automatic logic writes_rd(input logic [6:0] opc);
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
      OPC_OP, OPC_OPIMM, OPC_LOAD: writes_rd = 1'b1;
      default:                     writes_rd = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] imm_i(input logic [31:0] ir);
    imm_i = {{20{ir[31]}}, ir[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] ir);
    imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] ir);
    imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] ir);
    imm_u = {ir[31:12], 12'd0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] ir);
    imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  endfunction

  // Control outputs for a given state/IR/branch outcome. Evaluated on the
  // next-cycle values so the registered result lines up with the state.
  function automatic ctrl_t decode_ctrl(input state_t st, input logic [31:0] ir,
                                        input logic taken);
    ctrl_t      c;
    logic [6:0] opc;
    logic [2:0] f3;
    c        = '0;
    opc      = ir[6:0];
    f3       = ir[14:12];
    c.waddr  = ir[11:7];
    c.raddra = ir[19:15];
    c.raddrb = ir[24:20];
    case (opc)
      OPC_LUI: begin
        c.imm    = imm_u(ir);
        c.wb_sel = WB_IMM;
      end
      // AUIPC is an ALU add of the immediate; the datapath supplies PC as op1.
      OPC_AUIPC: begin
        c.imm         = imm_u(ir);
        c.alu_src_imm = 1'b1;
        c.wb_sel      = WB_ALU;
      end
      OPC_JAL: begin
        c.imm    = imm_j(ir);
        c.wb_sel = WB_PC4;
      end
      OPC_JALR: begin
        c.imm         = imm_i(ir);
        c.alu_src_imm = 1'b1;
        c.wb_sel      = WB_PC4;
      end
      OPC_BRANCH: begin
        c.imm = imm_b(ir);
        case (f3[2:1])
          2'b00:   c.alu_alt = 1'b1;       // BEQ/BNE: subtract, test zero
          2'b10:   c.alu_op  = 3'b010;     // BLT/BGE: signed compare
          2'b11:   c.alu_op  = 3'b011;     // BLTU/BGEU: unsigned compare
          default: c.alu_op  = 3'b000;
        endcase
      end
      OPC_LOAD: begin
        c.imm         = imm_i(ir);
        c.alu_src_imm = 1'b1;
        c.wb_sel      = WB_MEM;
      end
      OPC_STORE: begin
        c.imm         = imm_s(ir);
        c.alu_src_imm = 1'b1;
      end
      // funct7[5] only selects SRAI among the immediate forms.
      OPC_OPIMM: begin
        c.imm         = imm_i(ir);
        c.alu_src_imm = 1'b1;
        c.alu_op      = f3;
        c.alu_alt     = (f3 == 3'b101) ? ir[30] : 1'b0;
      end
      OPC_OP: begin
        c.alu_op  = f3;
        c.alu_alt = ir[30];
      end
      OPC_MISC, OPC_SYSTEM: c.imm = imm_i(ir);
      default:              c.imm = 32'd0;
    endcase
    case (st)
      S_FETCH: c.fetch_en = 1'b1;
      S_MEM: begin
        c.mem_req   = 1'b1;
        c.mem_write = (opc == OPC_STORE);
      end
      S_WRITEBACK: begin
        c.rf_we = writes_rd(opc) && (ir[11:7] != 5'd0);
        if ((opc == OPC_JAL) || (opc == OPC_JALR) || taken) begin
          c.pc_load = 1'b1;
        end else begin
          c.pc_inc  = 1'b1;
        end
      end
`ifdef CORE_SEQUENCER_TRAP_EN
      S_TRAP: c.halted = 1'b1;
`endif
      default: c.fetch_en = 1'b0;
    endcase
    return c;
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // Next state of the sequencer FSM.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH: w_state_nxt = S_DECODE;
      S_DECODE: begin
`ifdef CORE_SEQUENCER_TRAP_EN
        if (!is_known(instruction_i[6:0])) begin
          w_state_nxt = S_TRAP;
        end else begin
          w_state_nxt = S_EXECUTE;
        end
`else
        w_state_nxt = S_EXECUTE;
`endif
      end
      S_EXECUTE: begin
        if (is_mem(r_ir[6:0])) begin
          w_state_nxt = S_MEM;
        end else begin
          w_state_nxt = S_WRITEBACK;
        end
      end
      // mem_req_o is high throughout MEM, so mem_ready_i alone completes it.
      S_MEM: begin
        if (mem_ready_i) begin
          w_state_nxt = S_WRITEBACK;
        end else begin
          w_state_nxt = S_MEM;
        end
      end
      S_WRITEBACK: w_state_nxt = S_FETCH;
`ifdef CORE_SEQUENCER_TRAP_EN
      S_TRAP: w_state_nxt = S_TRAP;
`endif
      default: w_state_nxt = S_FETCH;
    endcase
  end

  // IR captures the instruction word only in DECODE.
  always_comb begin
    if (r_state == S_DECODE) begin
      w_ir_nxt = instruction_i;
    end else begin
      w_ir_nxt = r_ir;
    end
  end

  // Branch outcome: cmp_i flipped by funct3[0] (BNE/BGE/BGEU invert the test).
  always_comb begin
    if (r_state == S_EXECUTE) begin
      w_taken_nxt = (r_ir[6:0] == OPC_BRANCH) && (cmp_i ^ r_ir[12]);
    end else begin
      w_taken_nxt = r_taken;
    end
  end

  // Control outputs for the cycle about to begin.
  always_comb begin
    w_ctrl_nxt = decode_ctrl(w_state_nxt, w_ir_nxt, w_taken_nxt);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // State, IR and branch-outcome registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_FETCH;
      r_ir    <= 32'd0;
      r_taken <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ir    <= w_ir_nxt;
      r_taken <= w_taken_nxt;
    end
  end

  // Output register; reset loads the FETCH controls for a cleared IR, which
  // also drops any outstanding memory request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ctrl <= decode_ctrl(S_FETCH, 32'd0, 1'b0);
    end else begin
      r_ctrl <= w_ctrl_nxt;
    end
  end

  // Retired-instruction counter, bumped when leaving WRITEBACK.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_retired <= '0;
    end else if (r_state == S_WRITEBACK) begin
      r_retired <= r_retired + ICOUNT_W'(1);
    end else begin
      r_retired <= r_retired;
    end
  end

  assign fetch_en_o      = r_ctrl.fetch_en;
  assign pc_inc_o        = r_ctrl.pc_inc;
  assign pc_load_o       = r_ctrl.pc_load;
  assign regfile_write_o = r_ctrl.rf_we;
  assign waddr_o         = r_ctrl.waddr;
  assign raddra_o        = r_ctrl.raddra;
  assign raddrb_o        = r_ctrl.raddrb;
  assign alu_op_o        = r_ctrl.alu_op;
  assign alu_alt_op_o    = r_ctrl.alu_alt;
  assign alu_src_imm_o   = r_ctrl.alu_src_imm;
  assign imm_o           = r_ctrl.imm;
  assign mem_req_o       = r_ctrl.mem_req;
  assign mem_write_o     = r_ctrl.mem_write;
  assign wb_sel_o        = r_ctrl.wb_sel;
  assign state_o         = r_state;
  assign retired_o       = r_retired;
`ifdef CORE_SEQUENCER_TRAP_EN
  assign halted_o        = r_ctrl.halted;
`else
  assign halted_o        = 1'b0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
module tb_core_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] instruction_i;
  logic        cmp_i;
  logic        mem_ready_i;
  logic        fetch_en_o, pc_inc_o, pc_load_o, regfile_write_o;
  logic [4:0]  waddr_o, raddra_o, raddrb_o;
  logic [2:0]  alu_op_o;
  logic        alu_alt_op_o, alu_src_imm_o;
  logic [31:0] imm_o;
  logic        mem_req_o, mem_write_o;
  logic [1:0]  wb_sel_o;
  logic [2:0]  state_o;
  logic [3:0]  retired_o;
  logic        halted_o;

  int          n_cmp;
  int          n_fail;
  logic [3:0]  exp_ret;

  core_sequencer #(.ICOUNT_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .instruction_i(instruction_i), .cmp_i(cmp_i),
    .mem_ready_i(mem_ready_i), .fetch_en_o(fetch_en_o), .pc_inc_o(pc_inc_o),
    .pc_load_o(pc_load_o), .regfile_write_o(regfile_write_o), .waddr_o(waddr_o),
    .raddra_o(raddra_o), .raddrb_o(raddrb_o), .alu_op_o(alu_op_o),
    .alu_alt_op_o(alu_alt_op_o), .alu_src_imm_o(alu_src_imm_o), .imm_o(imm_o),
    .mem_req_o(mem_req_o), .mem_write_o(mem_write_o), .wb_sel_o(wb_sel_o),
    .state_o(state_o), .retired_o(retired_o), .halted_o(halted_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Starting in FETCH, apply an instruction and advance until WRITEBACK.
  task automatic run_to_wb(input logic [31:0] instr, input logic cmp, output int steps);
    instruction_i = instr;
    cmp_i         = cmp;
    mem_ready_i   = 1'b1;
    steps         = 0;
    while (steps < 12 && state_o != 3'd4) begin
      step();
      steps++;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    step();
    step();
    n_cmp++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state_o); end
    n_cmp++; if (retired_o !== 4'd0) begin n_fail++; $display("FAIL reset_retired: got %0d want 0", retired_o); end
    n_cmp++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req_o); end
    n_cmp++; if ({pc_inc_o, pc_load_o, regfile_write_o, halted_o} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 0000", {pc_inc_o, pc_load_o, regfile_write_o, halted_o}); end
    n_cmp++; if ({imm_o, waddr_o, alu_op_o} !== 40'd0) begin
      n_fail++; $display("FAIL reset_ir_ctrl: imm %h waddr %0d op %0d want 0", imm_o, waddr_o, alu_op_o); end
    rst_i = 1'b0;
  endtask

  task automatic test_addi();
    logic [11:0] seq;
    seq = {3'd4, 3'd2, 3'd1, 3'd0};
    instruction_i = 32'h0050_0093;
    cmp_i = 1'b0;
    mem_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      n_cmp++; if (state_o !== seq[i*3 +: 3]) begin n_fail++; $display("FAIL addi_state%0d: got %0d want %0d", i, state_o, seq[i*3 +: 3]); end
      n_cmp++; if (fetch_en_o !== (i == 0)) begin n_fail++; $display("FAIL addi_fetch_en%0d: got %b want %b", i, fetch_en_o, (i == 0)); end
    end
    n_cmp++; if ({regfile_write_o, waddr_o} !== {1'b1, 5'd1}) begin n_fail++; $display("FAIL addi_write: we %b waddr %0d want 1/1", regfile_write_o, waddr_o); end
    n_cmp++; if (imm_o !== 32'd5) begin n_fail++; $display("FAIL addi_imm: got %h want 5", imm_o); end
    n_cmp++; if ({alu_op_o, alu_src_imm_o, wb_sel_o} !== {3'b000, 1'b1, 2'b00}) begin
      n_fail++; $display("FAIL addi_alu: op %b src %b wb %b want 000/1/00", alu_op_o, alu_src_imm_o, wb_sel_o); end
    n_cmp++; if ({pc_inc_o, pc_load_o} !== 2'b10) begin n_fail++; $display("FAIL addi_pc: got %b want 10", {pc_inc_o, pc_load_o}); end
    n_cmp++; if (retired_o !== exp_ret) begin n_fail++; $display("FAIL addi_retired_wb: got %0d want %0d", retired_o, exp_ret); end
    step();
    exp_ret = exp_ret + 4'd1;
    n_cmp++; if (retired_o !== exp_ret) begin n_fail++; $display("FAIL addi_retired: got %0d want %0d", retired_o, exp_ret); end
  endtask

  task automatic test_lw();
    int cycles, mreq, mcyc;
    logic mw, we;
    logic [1:0] wbsel;
    logic [4:0] wad;
    logic [31:0] wimm;
    cycles = 0; mreq = 0; mcyc = 0; mw = 1'b0; we = 1'b0; wbsel = 2'b00; wad = 5'd0; wimm = 32'd0;
    instruction_i = 32'h0080_A103;
    mem_ready_i = 1'b0;
    while (cycles < 20) begin
      step();
      cycles++;
      if (mem_req_o) mreq++;
      if (mem_write_o) mw = 1'b1;
      if (state_o == 3'd3) begin
        mcyc++;
        mem_ready_i = (mcyc >= 4);
      end else begin
        mem_ready_i = 1'b0;
      end
      if (state_o == 3'd4) begin
        we = regfile_write_o; wbsel = wb_sel_o; wad = waddr_o; wimm = imm_o;
      end
      if (state_o == 3'd0) break;
    end
    mem_ready_i = 1'b1;
    exp_ret = exp_ret + 4'd1;
    n_cmp++; if (cycles !== 8) begin n_fail++; $display("FAIL lw_cycles: got %0d want 8", cycles); end
    n_cmp++; if (mreq !== 4) begin n_fail++; $display("FAIL lw_mem_req_cycles: got %0d want 4", mreq); end
    n_cmp++; if (mw !== 1'b0) begin n_fail++; $display("FAIL lw_mem_write: got %b want 0", mw); end
    n_cmp++; if ({we, wbsel, wad} !== {1'b1, 2'b01, 5'd2}) begin n_fail++; $display("FAIL lw_wb: we %b sel %b waddr %0d want 1/01/2", we, wbsel, wad); end
    n_cmp++; if (wimm !== 32'd8) begin n_fail++; $display("FAIL lw_imm: got %h want 8", wimm); end
    n_cmp++; if (retired_o !== exp_ret) begin n_fail++; $display("FAIL lw_retired: got %0d want %0d", retired_o, exp_ret); end
  endtask

  task automatic test_branch();
    logic [31:0] ins [5];
    logic        cmp [5];
    logic        ld  [5];
    logic [2:0]  op  [5];
    logic        alt [5];
    int          steps;
    ins[0] = 32'h0020_8463; cmp[0] = 1'b1; ld[0] = 1'b1; op[0] = 3'b000; alt[0] = 1'b1; // BEQ taken
    ins[1] = 32'h0020_9463; cmp[1] = 1'b1; ld[1] = 1'b0; op[1] = 3'b000; alt[1] = 1'b1; // BNE not taken
    ins[2] = 32'h0020_8463; cmp[2] = 1'b0; ld[2] = 1'b0; op[2] = 3'b000; alt[2] = 1'b1; // BEQ not taken
    ins[3] = 32'h0020_C463; cmp[3] = 1'b1; ld[3] = 1'b1; op[3] = 3'b010; alt[3] = 1'b0; // BLT taken
    ins[4] = 32'h0020_F463; cmp[4] = 1'b0; ld[4] = 1'b1; op[4] = 3'b011; alt[4] = 1'b0; // BGEU taken
    for (int i = 0; i < 5; i++) begin
      run_to_wb(ins[i], cmp[i], steps);
      n_cmp++; if (steps !== 3) begin n_fail++; $display("FAIL br%0d_latency: got %0d want 3", i, steps); end
      n_cmp++; if ({pc_load_o, pc_inc_o} !== {ld[i], ~ld[i]}) begin n_fail++; $display("FAIL br%0d_pc: load/inc %b%b want %b%b", i, pc_load_o, pc_inc_o, ld[i], ~ld[i]); end
      n_cmp++; if (regfile_write_o !== 1'b0) begin n_fail++; $display("FAIL br%0d_write: got %b want 0", i, regfile_write_o); end
      n_cmp++; if ({alu_op_o, alu_alt_op_o} !== {op[i], alt[i]}) begin n_fail++; $display("FAIL br%0d_alu: got %b/%b want %b/%b", i, alu_op_o, alu_alt_op_o, op[i], alt[i]); end
      n_cmp++; if (imm_o !== 32'd8) begin n_fail++; $display("FAIL br%0d_imm: got %h want 8", i, imm_o); end
      step();
      exp_ret = exp_ret + 4'd1;
    end
    n_cmp++; if (retired_o !== exp_ret) begin n_fail++; $display("FAIL br_retired: got %0d want %0d", retired_o, exp_ret); end
  endtask

  task automatic test_jal_lui();
    int steps;
    run_to_wb(32'h0100_00EF, 1'b0, steps);   // JAL x1, +16
    n_cmp++; if ({pc_load_o, pc_inc_o, regfile_write_o} !== 3'b101) begin n_fail++; $display("FAIL jal_strobes: got %b want 101", {pc_load_o, pc_inc_o, regfile_write_o}); end
    n_cmp++; if ({wb_sel_o, imm_o} !== {2'b10, 32'd16}) begin n_fail++; $display("FAIL jal_wb_imm: sel %b imm %h want 10/10", wb_sel_o, imm_o); end
    step();
    exp_ret = exp_ret + 4'd1;
    run_to_wb(32'h1234_52B7, 1'b0, steps);   // LUI x5, 0x12345
    n_cmp++; if ({wb_sel_o, imm_o} !== {2'b11, 32'h1234_5000}) begin n_fail++; $display("FAIL lui_wb_imm: sel %b imm %h want 11/12345000", wb_sel_o, imm_o); end
    n_cmp++; if ({regfile_write_o, waddr_o, pc_inc_o} !== {1'b1, 5'd5, 1'b1}) begin n_fail++; $display("FAIL lui_write: we %b waddr %0d inc %b want 1/5/1", regfile_write_o, waddr_o, pc_inc_o); end
    step();
    exp_ret = exp_ret + 4'd1;
  endtask

  task automatic test_x0();
    int steps;
    run_to_wb(32'h0010_0013, 1'b0, steps);
    n_cmp++; if (steps !== 3) begin n_fail++; $display("FAIL x0_latency: got %0d want 3", steps); end
    n_cmp++; if ({regfile_write_o, pc_inc_o, imm_o} !== {1'b0, 1'b1, 32'd1}) begin n_fail++; $display("FAIL x0_wb: we %b inc %b imm %h want 0/1/1", regfile_write_o, pc_inc_o, imm_o); end
    step();
    exp_ret = exp_ret + 4'd1;
    n_cmp++; if (retired_o !== exp_ret) begin n_fail++; $display("FAIL x0_retired: got %0d want %0d", retired_o, exp_ret); end
  endtask

  task automatic test_illegal();
`ifdef CORE_SEQUENCER_TRAP_EN
    instruction_i = 32'hFFFF_FFFF;
    step();
    step();
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if ({state_o, halted_o} !== {3'd5, 1'b1}) begin n_fail++; $display("FAIL trap_hold%0d: state %0d halted %b want 5/1", i, state_o, halted_o); end
      n_cmp++; if ({fetch_en_o, pc_inc_o, pc_load_o, regfile_write_o, mem_req_o} !== 5'd0) begin n_fail++; $display("FAIL trap_strobes%0d: nonzero strobe", i); end
      n_cmp++; if (retired_o !== exp_ret) begin n_fail++; $display("FAIL trap_retired%0d: got %0d want %0d", i, retired_o, exp_ret); end
      step();
    end
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    exp_ret = 4'd0;
    n_cmp++; if ({state_o, halted_o} !== {3'd0, 1'b0}) begin n_fail++; $display("FAIL trap_exit: state %0d halted %b want 0/0", state_o, halted_o); end
`else
    int steps;
    run_to_wb(32'hFFFF_FFFF, 1'b0, steps);
    n_cmp++; if (steps !== 3) begin n_fail++; $display("FAIL illegal_latency: got %0d want 3", steps); end
    n_cmp++; if ({pc_inc_o, pc_load_o, regfile_write_o, halted_o} !== 4'b1000) begin n_fail++; $display("FAIL illegal_nop: got %b want 1000", {pc_inc_o, pc_load_o, regfile_write_o, halted_o}); end
    step();
    exp_ret = exp_ret + 4'd1;
    n_cmp++; if (retired_o !== exp_ret) begin n_fail++; $display("FAIL illegal_retired: got %0d want %0d", retired_o, exp_ret); end
`endif
  endtask

  task automatic test_reset_mem();
    int cycles;
    cycles = 0;
    instruction_i = 32'h0080_A103;
    mem_ready_i = 1'b0;
    while (cycles < 10 && state_o != 3'd3) begin
      step();
      cycles++;
    end
    step();
    n_cmp++; if ({state_o, mem_req_o} !== {3'd3, 1'b1}) begin n_fail++; $display("FAIL rstmem_wait: state %0d req %b want 3/1", state_o, mem_req_o); end
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    mem_ready_i = 1'b1;
    exp_ret = 4'd0;
    n_cmp++; if ({state_o, mem_req_o} !== {3'd0, 1'b0}) begin n_fail++; $display("FAIL rstmem_after: state %0d req %b want 0/0", state_o, mem_req_o); end
    n_cmp++; if (retired_o !== 4'd0) begin n_fail++; $display("FAIL rstmem_retired: got %0d want 0", retired_o); end
  endtask

  task automatic test_wrap();
    int steps;
    int guard;
    guard = 0;
    while (exp_ret != 4'hF && guard < 20) begin
      run_to_wb(32'h0010_0013, 1'b0, steps);
      step();
      exp_ret = exp_ret + 4'd1;
      guard++;
    end
    n_cmp++; if (retired_o !== 4'hF) begin n_fail++; $display("FAIL wrap_allones: got %h want f", retired_o); end
    run_to_wb(32'h0010_0013, 1'b0, steps);
    step();
    n_cmp++; if (retired_o !== 4'h0) begin n_fail++; $display("FAIL wrap_zero: got %h want 0", retired_o); end
  endtask

  initial begin
    rst_i = 1'b1; instruction_i = 32'd0; cmp_i = 1'b0; mem_ready_i = 1'b0;
    n_cmp = 0; n_fail = 0; exp_ret = 4'd0;
    test_reset();
    test_addi();
    test_lw();
    test_branch();
    test_jal_lui();
    test_x0();
    test_illegal();
    test_reset_mem();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule
